// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - multi-channel PWM LED driver with breathing envelope and colour sequencer
// Define RGB_PWM_GAMMA_EN to square the duty (after breathing) before it is loaded into the shadow.
module rgb_pwm_sequencer #(
  parameter int CH       = 3,
  parameter int PWM_W    = 8,
  parameter int STEPS    = 7,
  parameter int BREATH_W = 8,
  parameter int PRESC_W  = 16,
  parameter int HOLD_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [1:0]                      mode,
  input  logic [PRESC_W-1:0]              prescale,
  input  logic [HOLD_W-1:0]               hold_frames,
  input  logic [STEPS*CH*PWM_W-1:0]       duty_bank,
  output logic [CH-1:0]                   pwm_out,
  output logic                            frame_tick,
  output logic [$clog2(STEPS)-1:0]        step_idx,
  output logic [BREATH_W-1:0]             level
);

  localparam int STEP_W = $clog2(STEPS);
  localparam logic [BREATH_W-1:0] LVL_MAX = {BREATH_W{1'b1}};
  localparam logic [PWM_W-1:0]    CNT_MAX = {PWM_W{1'b1}};

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t                dir_q, dir_d;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [HOLD_W-1:0]   hold_cnt, hold_d, hold_max;
  logic [STEP_W-1:0]   step_d, step_next;
  logic [BREATH_W-1:0] level_d;
  logic                breath_zero;
  logic                tick;
  logic [1:0]          mode_sh;
  logic [PWM_W-1:0]    duty_sh  [CH];
  logic [PWM_W-1:0]    eff_duty [CH];
  logic [PWM_W-1:0]    bank     [STEPS][CH];

  // Prescaler reaching its terminal count; >= keeps it from running away if prescale shrinks mid-count.
  assign tick       = en && (presc_cnt >= prescale);
  assign frame_tick = tick && (pwm_cnt == CNT_MAX);

  // Unpack the flat colour bank into [entry][channel].
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    for (genvar c = 0; c < CH; c++) begin : g_bch
      assign bank[s][c] = duty_bank[(s*CH+c)*PWM_W +: PWM_W];
    end
  end

  // Per-channel effective duty: optional breathing scale, then optional gamma.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [PWM_W-1:0]          raw;
    logic [PWM_W+BREATH_W-1:0] scaled;
    logic [PWM_W-1:0]          lin;
    assign raw    = bank[step_idx][c];
    assign scaled = (PWM_W+BREATH_W)'(raw) * (PWM_W+BREATH_W)'(level);
    assign lin    = mode_sh[0] ? PWM_W'(scaled >> BREATH_W) : raw;
`ifdef RGB_PWM_GAMMA_EN
    logic [2*PWM_W-1:0] sq;
    assign sq          = (2*PWM_W)'(lin) * (2*PWM_W)'(lin);
    assign eff_duty[c] = (&lin) ? lin : PWM_W'(sq >> PWM_W);
`else
    assign eff_duty[c] = lin;
`endif
  end

  // Prescaler and PWM frame counter; both freeze while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (en) begin
      if (tick) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + PWM_W'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end
    end
  end

  // Frame-synchronous shadow load and registered PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sh <= 2'b00;
      pwm_out <= '0;
      for (int c = 0; c < CH; c++) duty_sh[c] <= '0;
    end else begin
      if (frame_tick) begin
        mode_sh <= mode;
        for (int c = 0; c < CH; c++) duty_sh[c] <= eff_duty[c];
      end
      for (int c = 0; c < CH; c++)
        pwm_out[c] <= en && ((&duty_sh[c]) || (pwm_cnt < duty_sh[c]));
    end
  end

  assign hold_max  = (hold_frames == '0) ? HOLD_W'(1) : hold_frames;
  assign step_next = (step_idx == STEP_W'(STEPS-1)) ? '0 : step_idx + STEP_W'(1);

  // Next-state for breathing direction/level and the colour-step sequencer (uses the old mode_sh).
  always_comb begin
    dir_d       = dir_q;
    level_d     = level;
    step_d      = step_idx;
    hold_d      = hold_cnt;
    breath_zero = 1'b0;
    if (frame_tick && mode_sh[0]) begin
      if (dir_q == UP) begin
        if (level == LVL_MAX) begin
          dir_d   = DOWN;
          level_d = LVL_MAX - BREATH_W'(1);
        end else begin
          level_d = level + BREATH_W'(1);
        end
      end else begin
        if (level == '0) begin
          dir_d   = UP;
          level_d = BREATH_W'(1);
        end else begin
          level_d     = level - BREATH_W'(1);
          breath_zero = (level == BREATH_W'(1));
        end
      end
    end
    if (en && !mode_sh[1]) begin
      hold_d = '0;
    end else if (frame_tick && mode_sh[1]) begin
      if (mode_sh[0]) begin
        hold_d = '0;
        if (breath_zero) step_d = step_next;
      end else if (hold_cnt >= hold_max - HOLD_W'(1)) begin
        hold_d = '0;
        step_d = step_next;
      end else begin
        hold_d = hold_cnt + HOLD_W'(1);
      end
    end
  end

  // State register for the breathing FSM and sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= UP;
      level    <= '0;
      step_idx <= '0;
      hold_cnt <= '0;
    end else begin
      dir_q    <= dir_d;
      level    <= level_d;
      step_idx <= step_d;
      hold_cnt <= hold_d;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - self-checking bench for rgb_pwm_sequencer
module tb_rgb_pwm_sequencer;

  localparam int CH  = 3;
  localparam int PW  = 8;
  localparam int ST  = 7;
  localparam int BW  = 8;
  localparam int SCH = 1;
  localparam int SPW = 4;
  localparam int SST = 3;
  localparam int SBW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en;
  logic [1:0] mode;
  logic [15:0] prescale, hold_frames;
  logic [ST*CH*PW-1:0] duty_bank;
  logic [CH-1:0] pwm_out;
  logic frame_tick;
  logic [2:0] step_idx;
  logic [BW-1:0] level;

  logic s_en;
  logic [1:0] s_mode;
  logic [15:0] s_prescale, s_hold;
  logic [SST*SCH*SPW-1:0] s_bank;
  logic [SCH-1:0] s_pwm;
  logic s_ft;
  logic [1:0] s_step;
  logic [SBW-1:0] s_level;

  int total = 0;
  int bad = 0;

  int m_mode_sh, m_adv, m_step, m_seq_frames;
  int m_duty [CH];

  always #5 clk = ~clk;

  rgb_pwm_sequencer #(.CH(CH), .PWM_W(PW), .STEPS(ST), .BREATH_W(BW), .PRESC_W(16), .HOLD_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .prescale(prescale), .hold_frames(hold_frames),
    .duty_bank(duty_bank), .pwm_out(pwm_out), .frame_tick(frame_tick), .step_idx(step_idx), .level(level)
  );

  rgb_pwm_sequencer #(.CH(SCH), .PWM_W(SPW), .STEPS(SST), .BREATH_W(SBW), .PRESC_W(16), .HOLD_W(16)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .mode(s_mode), .prescale(s_prescale), .hold_frames(s_hold),
    .duty_bank(s_bank), .pwm_out(s_pwm), .frame_tick(s_ft), .step_idx(s_step), .level(s_level)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Triangle envelope: level after n advances from 0 going up, peak mx.
  function automatic int tri_level(input int n, input int mx);
    int p;
    p = n % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  function automatic int bank_get(input int s, input int c);
    return int'(duty_bank[(s*CH+c)*PW +: PW]);
  endfunction

  task automatic set_bank(input int s, input int c, input int v);
    duty_bank[(s*CH+c)*PW +: PW] = PW'(v);
  endtask

  // Frame boundary in the reference: next frame's duties, then envelope/step with the old mode.
  task automatic model_tick();
    int lvl, hold_eff;
    lvl = tri_level(m_adv, 255);
    for (int c = 0; c < CH; c++) begin
      m_duty[c] = bank_get(m_step, c);
      if ((m_mode_sh & 1) != 0) m_duty[c] = (m_duty[c] * lvl) >> BW;
    end
    if ((m_mode_sh & 1) != 0) m_adv++;
    hold_eff = (hold_frames == 0) ? 1 : int'(hold_frames);
    if (m_mode_sh == 2) begin
      m_seq_frames++;
      if (m_seq_frames % hold_eff == 0) m_step = (m_step + 1) % ST;
    end else begin
      m_seq_frames = 0;
      if (m_mode_sh == 3 && (m_adv % 510) == 0) m_step = (m_step + 1) % ST;
    end
    m_mode_sh = int'(mode);
  endtask

  // Precondition: at the sample just after a frame_tick sample. Measures one frame.
  // act 1: at sample act_at set entry m_step, R to act_arg. act 2: drop en for act_arg clk at act_at.
  task automatic measure_frame(input int act, input int act_at, input int act_arg);
    int hi [CH];
    int exp_d [CH];
    int len, base, flen;
    bit last_ft;
    exp_d = m_duty;
    base = 256 * (int'(prescale) + 1);
    flen = base + ((act == 2) ? act_arg : 0);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    len = 0;
    last_ft = frame_tick;
    while (1) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
      len++;
      if (act == 1 && len == act_at) set_bank(m_step, 0, act_arg);
      if (act == 2 && len == act_at) en = 1'b0;
      if (act == 2 && len == act_at + 1) check("en_off_pwm_r", int'(pwm_out[0]), 0);
      if (act == 2 && len == act_at + act_arg) en = 1'b1;
      if (last_ft) break;
      last_ft = frame_tick;
      if (frame_tick) model_tick();
      if (len > 4 * flen + 16) begin
        check("frame_timeout", len, flen);
        break;
      end
    end
    check("frame_len", len, flen);
    for (int c = 0; c < CH; c++)
      check($sformatf("hi_ch%0d", c), hi[c], (exp_d[c] == 255) ? base : exp_d[c] * (int'(prescale) + 1));
    check("level", int'(level), tri_level(m_adv, 255));
    check("step_idx", int'(step_idx), m_step);
  endtask

  initial begin
    bit found;
    en = 1'b0; mode = 2'b00; prescale = 16'd0; hold_frames = 16'd2; duty_bank = '0;
    s_en = 1'b0; s_mode = 2'b11; s_prescale = 16'd0; s_hold = 16'd0; s_bank = '0;
    m_mode_sh = 0; m_adv = 0; m_step = 0; m_seq_frames = 0;
    for (int c = 0; c < CH; c++) m_duty[c] = 0;

    #2 rst = 1'b1;
    #1;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ft", int'(frame_tick), 0);
    check("rst_step", int'(step_idx), 0);
    check("rst_level", int'(level), 0);
    check("rst_s_level", int'(s_level), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // static colours at entry 0, random other entries
    for (int s = 1; s < ST; s++)
      for (int c = 0; c < CH; c++) set_bank(s, c, $urandom_range(0, 255));
    set_bank(0, 0, 64); set_bank(0, 1, 0); set_bank(0, 2, 255);
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (frame_tick) found = 1;
    end
    check("first_frame_tick", int'(found), 1);
    model_tick();
    @(negedge clk);
    repeat (3) measure_frame(0, 0, 0);

    // mid-frame duty change takes effect only at the next frame
    measure_frame(1, 100, 128);
    measure_frame(0, 0, 0);
    for (int c = 0; c < CH; c++) set_bank(0, c, $urandom_range(0, 255));
    repeat (2) measure_frame(0, 0, 0);

    // breathing up to past level 128
    set_bank(0, 0, 255);
    set_bank(0, 1, $urandom_range(0, 255));
    set_bank(0, 2, $urandom_range(0, 255));
    mode = 2'b01;
    repeat (132) measure_frame(0, 0, 0);

    // colour sequencing, hold 2 then hold 0
    for (int s = 0; s < ST; s++)
      for (int c = 0; c < CH; c++) set_bank(s, c, $urandom_range(0, 255));
    mode = 2'b10;
    hold_frames = 16'd2;
    repeat (17) measure_frame(0, 0, 0);
    hold_frames = 16'd0;
    repeat (8) measure_frame(0, 0, 0);

    // en dropped mid-frame
    mode = 2'b00;
    measure_frame(0, 0, 0);
    set_bank(m_step, 0, $urandom_range(150, 250));
    measure_frame(0, 0, 0);
    measure_frame(2, 100, $urandom_range(10, 60));

    // prescale 3
    prescale = 16'd3;
    set_bank(m_step, 0, 64);
    repeat (2) measure_frame(0, 0, 0);

    // async reset mid-frame
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm", int'(pwm_out), 0);
    check("arst_step", int'(step_idx), 0);
    check("arst_level", int'(level), 0);
    check("arst_ft", int'(frame_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;

    // sequence+breathe on a small instance: full triangles and step wrap
    begin
      int sm_mode_sh, sm_adv, sm_step;
      sm_mode_sh = 0; sm_adv = 0; sm_step = 0;
      for (int s = 0; s < SST; s++) s_bank[s*SPW +: SPW] = SPW'($urandom_range(0, 15));
      s_mode = 2'b11;
      s_en = 1'b1;
      for (int f = 0; f < 50; f++) begin
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
          @(negedge clk);
          if (s_ft) found = 1;
        end
        if (!found) begin
          check("s_frame_timeout", 0, 1);
          break;
        end
        if (sm_mode_sh == 3) begin
          sm_adv++;
          if (sm_adv % 14 == 0) sm_step = (sm_step + 1) % SST;
        end
        sm_mode_sh = int'(s_mode);
        @(negedge clk);
        check("s_level", int'(s_level), tri_level(sm_adv, 7));
        check("s_step", int'(s_step), sm_step);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
